// File: rtl/uart_pkg.sv
// uart_pkg
// Definitions shared by the UART transmitter and receiver.
//   PAR_NONE / PAR_ODD / PAR_EVEN : parity mode selectors
//   uart_state_e                  : one-hot frame state encoding
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_START  = 5'b00010,
    ST_DATA   = 5'b00100,
    ST_PARITY = 5'b01000,
    ST_STOP   = 5'b10000
  } uart_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Synchronous word FIFO feeding the UART transmit shifter. The read port
// shows the head word combinationally so it can be loaded on the pop edge.
//   i_CLK, i_RESET_n : clock, async active-low reset (clears pointers/count)
//   push, wr_data    : write request; ignored while full
//   pop, rd_data     : read request; ignored while empty; rd_data = head word
//   full, empty      : status
//   count            : number of words stored
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_CLK,
  input  logic                          i_RESET_n,
  input  logic                          push,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic                          pop,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  // A write against a full FIFO is dropped even when a pop happens alongside.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_CLK) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame
// Buffered UART transmitter: words from an internal FIFO are sent as
// START, DATA_BITS data bits (LSB first), optional parity, STOP_BITS stops.
// Back-to-back frames follow each other with no idle gap.
//   i_CLK, i_RESET_n : clock, async active-low reset
//   i_TX_DV          : write strobe, accepted when o_READY=1
//   i_PARALLEL_DATA  : word to transmit
//   o_READY          : FIFO not full
//   o_FIFO_COUNT     : words buffered (not counting the word being shifted)
//   o_SERIAL_DATA    : registered serial line, idle high
//   o_TX_ACTIVE      : frame in progress
//   o_TX_DONE        : one-cycle pulse after each completed frame
//
// state     | meaning
// ST_IDLE   | line high, waiting for a buffered word
// ST_START  | start bit (line low)
// ST_DATA   | data bits, shifter[0] on the line
// ST_PARITY | parity bit captured at pop time
// ST_STOP   | STOP_BITS stop bits (line high), may chain into ST_START
module uart_tx_frame #(
  parameter int CYCLES_PER_BIT = 434,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                        i_CLK,
  input  logic                        i_RESET_n,
  input  logic                        i_TX_DV,
  input  logic [DATA_BITS-1:0]        i_PARALLEL_DATA,
  output logic                        o_READY,
  output logic [$clog2(FIFO_DEPTH):0] o_FIFO_COUNT,
  output logic                        o_SERIAL_DATA,
  output logic                        o_TX_ACTIVE,
  output logic                        o_TX_DONE
);

  import uart_pkg::*;

  localparam logic [31:0] BAUD_LAST = 32'(CYCLES_PER_BIT - 1);
  localparam logic [3:0]  DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]  STOP_LAST = 4'(STOP_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [31:0]          baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 line_d, done_d, active_d;
  logic                 bit_end;
  logic                 word_parity;
  logic                 fifo_pop, fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_rd_data;

  uart_tx_fifo #(
    .DATA_BITS  (DATA_BITS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_CLK     (i_CLK),
    .i_RESET_n (i_RESET_n),
    .push      (i_TX_DV),
    .wr_data   (i_PARALLEL_DATA),
    .pop       (fifo_pop),
    .rd_data   (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (o_FIFO_COUNT)
  );

  assign o_READY = ~fifo_full;
  assign bit_end = (baud_q == BAUD_LAST);
  // Parity comes from the head word as it is popped, not from the shifter.
  assign word_parity = (PARITY == PAR_EVEN) ? ^fifo_rd_data : ~^fifo_rd_data;

  always_comb begin
    state_d  = state_q;
    baud_d   = bit_end ? '0 : baud_q + 32'd1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    fifo_pop = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rd_data;
          par_d    = word_parity;
          bit_d    = '0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          bit_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d   = bit_q + 4'd1;
            shift_d = shift_q >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            done_d = 1'b1;
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              shift_d  = fifo_rd_data;
              par_d    = word_parity;
              bit_d    = '0;
              state_d  = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line level is decoded from the next state so the output register
    // changes on the same edge as the state.
    case (state_d)
      ST_START:  line_d = 1'b0;
      ST_DATA:   line_d = shift_d[0];
      ST_PARITY: line_d = par_d;
      default:   line_d = 1'b1;
    endcase
    active_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      state_q       <= ST_IDLE;
      baud_q        <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      par_q         <= 1'b0;
      o_SERIAL_DATA <= 1'b1;
      o_TX_ACTIVE   <= 1'b0;
      o_TX_DONE     <= 1'b0;
    end else begin
      state_q       <= state_d;
      baud_q        <= baud_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      par_q         <= par_d;
      o_SERIAL_DATA <= line_d;
      o_TX_ACTIVE   <= active_d;
      o_TX_DONE     <= done_d;
    end
  end

endmodule
